game_round_sequencer: RTL and testbench
=======================================

Name: game_round_sequencer

Overview:
Top-level round controller for the guessing game. It owns the sequence "draw random target → spin motor to it → wait for keypad guess (with timeout) → judge → show result" across a fixed number of rounds. It gates the random generator, triggers the motor, filters keypad strobes, and keeps round and score counts for the 7-segment display.

Parameters:
GUESS_TIMEOUT, 250_000_000, clk cycles allowed for a guess in WAIT_KEY before the round counts as a miss (≥2)
RESULT_HOLD, 100_000_000, clk cycles show_result stays high per round (≥1)
MAX_ROUNDS, 9, rounds per game (1..15)

Ports:
clk  in  1  system clock
res  in  1  asynchronous active-high reset
start  in  1  synchronous level from button; rising edge starts a game
rand_num  in  4  current random generator output
rand_enable  out  1  random generator run enable
motor_start  out  1  one-cycle pulse commanding motor to position target
motor_busy  in  1  high while motor is moving
key_code  in  4  keypad code, valid when key_valid=1
key_valid  in  1  one-cycle keypad strobe
target  out  4  latched random target for current round
round_cnt  out  4  completed rounds in current game
score  out  4  hits in current game
show_result  out  1  high during result display window
result_hit  out  1  last judged round was a hit (valid while show_result=1)
game_over  out  1  high in DONE
state_dbg  out  3  encoded state: IDLE=0 ROLL=1 LATCH=2 SPIN=3 WAIT_KEY=4 JUDGE=5 SHOW=6 DONE=7

Behaviour:
- Reset (async, any state): state=IDLE; every output 0; start edge detector register=0; all internal counters=0.
- start edge: start_q registered each cycle; edge = start & ~start_q. Edges are acted on in IDLE and DONE only, ignored elsewhere.
- IDLE: rand_enable=0. On edge, clear score and round_cnt, then go to ROLL.
- ROLL: rand_enable=1 for exactly 1 cycle, then LATCH.
- LATCH: target<=rand_num; motor_start=1 for this cycle only; go to SPIN; clear spin counter.
- SPIN: stay at least 2 cycles so motor_busy can rise. From the 3rd cycle on, exit to WAIT_KEY on the first cycle with motor_busy=0. Clear timeout counter and miss flag on exit.
- WAIT_KEY: timeout counter increments each cycle.
  - key_valid=1: capture key_code, go to JUDGE.
  - Else counter reaches GUESS_TIMEOUT-1: set miss flag, go to JUDGE.
  - key_valid in the same cycle as the timeout: the key wins.
  - key_valid in any other state is ignored.
- JUDGE (1 cycle): hit = ~miss & (captured==target). result_hit<=hit. score<=score+hit, saturating at 15. round_cnt<=round_cnt+1. Go to SHOW; clear hold counter.
- SHOW: show_result=1 for exactly RESULT_HOLD cycles. Then go to DONE if round_cnt==MAX_ROUNDS, else ROLL.
- DONE: game_over=1; target, score and round_cnt are held. On edge: clear score, round_cnt and game_over, then go to ROLL (skips IDLE).
- Outputs are registered except rand_enable and motor_start, which are decoded from state. state_dbg mirrors state.
- Unused state encodings are not possible with 3 bits. All transitions are synchronous except reset.
- Counters are sized for ceil(log2(max param)). No wrap: each counter is cleared on state entry.

Test Plan (GUESS_TIMEOUT=20, RESULT_HOLD=4, MAX_ROUNDS=2):
1. Reset, then start rising → rand_enable high 1 cycle; next cycle target=rand_num (drive 4'h7) and motor_start pulses once; state_dbg 1→2→3.
2. Hit path: motor_busy high 5 cycles then low → WAIT_KEY. key_code=7 with key_valid → JUDGE; then show_result high exactly 4 cycles, result_hit=1, score=1, round_cnt=1, then ROLL.
3. Timeout: no key for 20 cycles in WAIT_KEY → result_hit=0, score unchanged, round_cnt=2, then DONE with game_over=1.
4. Key coincident with the final timeout cycle, key_code==target → counted as hit.
5. start edges and key_valid pulses during SPIN/SHOW → no effect on state or counters. start edge in DONE → score=0, round_cnt=0, game_over=0, ROLL.
6. res asserted mid-WAIT_KEY (not clock-aligned) → all outputs 0 immediately, state_dbg=0; after res releases, block waits for a new start edge.

Source files
------------

// File: rtl/game_round_sequencer.sv
// Round controller for the guessing game: draw target, spin motor, await guess
// with timeout, judge, show result, repeated for a fixed number of rounds.
module game_round_sequencer #(
    parameter int unsigned GUESS_TIMEOUT = 250_000_000,
    parameter int unsigned RESULT_HOLD   = 100_000_000,
    parameter int unsigned MAX_ROUNDS    = 9
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic [3:0] rand_num,
    output logic       rand_enable,
    output logic       motor_start,
    input  logic       motor_busy,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic [3:0] target,
    output logic [3:0] round_cnt,
    output logic [3:0] score,
    output logic       show_result,
    output logic       result_hit,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    localparam int unsigned TO_W   = $clog2(GUESS_TIMEOUT);
    localparam int unsigned HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ROLL     = 3'd1,
        S_LATCH    = 3'd2,
        S_SPIN     = 3'd3,
        S_WAIT_KEY = 3'd4,
        S_JUDGE    = 3'd5,
        S_SHOW     = 3'd6,
        S_DONE     = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic                start_q;
    logic [3:0]          target_q, target_d;
    logic [3:0]          round_q, round_d;
    logic [3:0]          score_q, score_d;
    logic                show_q, show_d;
    logic                hit_q, hit_d;
    logic                over_q, over_d;
    logic [1:0]          spin_q, spin_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                miss_q, miss_d;
    logic [3:0]          key_q, key_d;

    logic start_edge;
    logic judge_hit;

    assign start_edge = start & ~start_q;
    assign judge_hit  = ~miss_q & (key_q == target_q);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            target_q <= 4'd0;
            round_q  <= 4'd0;
            score_q  <= 4'd0;
            show_q   <= 1'b0;
            hit_q    <= 1'b0;
            over_q   <= 1'b0;
            spin_q   <= 2'd0;
            to_q     <= '0;
            hold_q   <= '0;
            miss_q   <= 1'b0;
            key_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            target_q <= target_d;
            round_q  <= round_d;
            score_q  <= score_d;
            show_q   <= show_d;
            hit_q    <= hit_d;
            over_q   <= over_d;
            spin_q   <= spin_d;
            to_q     <= to_d;
            hold_q   <= hold_d;
            miss_q   <= miss_d;
            key_q    <= key_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        round_d  = round_q;
        score_d  = score_q;
        hit_d    = hit_q;
        spin_d   = spin_q;
        to_d     = to_q;
        hold_d   = hold_q;
        miss_d   = miss_q;
        key_d    = key_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    score_d = 4'd0;
                    round_d = 4'd0;
                    state_d = S_ROLL;
                end
            end
            S_ROLL: state_d = S_LATCH;
            S_LATCH: begin
                target_d = rand_num;
                spin_d   = 2'd0;
                state_d  = S_SPIN;
            end
            // Minimum dwell of two cycles gives motor_busy time to assert.
            S_SPIN: begin
                if (spin_q != 2'd2) begin
                    spin_d = spin_q + 2'd1;
                end else if (!motor_busy) begin
                    to_d    = '0;
                    miss_d  = 1'b0;
                    state_d = S_WAIT_KEY;
                end
            end
            // A key arriving on the final timeout cycle takes priority.
            S_WAIT_KEY: begin
                to_d = to_q + TO_W'(1);
                if (key_valid) begin
                    key_d   = key_code;
                    state_d = S_JUDGE;
                end else if (to_q == TO_W'(GUESS_TIMEOUT - 1)) begin
                    miss_d  = 1'b1;
                    state_d = S_JUDGE;
                end
            end
            S_JUDGE: begin
                hit_d = judge_hit;
                if (judge_hit && (score_q != 4'hF)) begin
                    score_d = score_q + 4'd1;
                end
                round_d = round_q + 4'd1;
                hold_d  = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_W'(RESULT_HOLD - 1)) begin
                    state_d = (round_q == 4'(MAX_ROUNDS)) ? S_DONE : S_ROLL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        show_d = (state_d == S_SHOW);
        over_d = (state_d == S_DONE);
    end

    assign rand_enable = (state_q == S_ROLL);
    assign motor_start = (state_q == S_LATCH);
    assign target      = target_q;
    assign round_cnt   = round_q;
    assign score       = score_q;
    assign show_result = show_q;
    assign result_hit  = hit_q;
    assign game_over   = over_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Scoreboard bench for game_round_sequencer: stimulus queues expected targets
// and round results, an independent monitor checks them as the DUT shows them.
module tb_game_round_sequencer;

    localparam int unsigned GT = 20;
    localparam int unsigned RH = 4;
    localparam int unsigned MR = 2;

    typedef struct packed {
        logic       hit;
        logic [3:0] score;
        logic [3:0] round;
    } exp_t;

    logic       clk, res, start, motor_busy, key_valid;
    logic [3:0] rand_num, key_code;
    logic       rand_enable, motor_start, show_result, result_hit, game_over;
    logic [3:0] target, round_cnt, score;
    logic [2:0] state_dbg;

    exp_t       res_q[$];
    logic [3:0] tgt_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    game_round_sequencer #(
        .GUESS_TIMEOUT(GT),
        .RESULT_HOLD  (RH),
        .MAX_ROUNDS   (MR)
    ) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .rand_num   (rand_num),
        .rand_enable(rand_enable),
        .motor_start(motor_start),
        .motor_busy (motor_busy),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .target     (target),
        .round_cnt  (round_cnt),
        .score      (score),
        .show_result(show_result),
        .result_hit (result_hit),
        .game_over  (game_over),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc);
        int n;
        n = 0;
        while (state_dbg != st && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", int'(state_dbg), int'(st));
    endtask

    function automatic int all_outs();
        return int'({rand_enable, motor_start, target, round_cnt, score,
                     show_result, result_hit, game_over, state_dbg});
    endfunction

    // Monitor: checks target after each motor_start and results on each show window.
    initial begin
        logic ms_prev, sh_prev;
        int   sh_len;
        exp_t e;
        ms_prev = 1'b0;
        sh_prev = 1'b0;
        sh_len  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (res) begin
                ms_prev = 1'b0;
                sh_prev = 1'b0;
                sh_len  = 0;
            end else begin
                if (ms_prev) begin
                    if (tgt_q.size() == 0) chk("target_unexpected", 1, 0);
                    else chk("target", int'(target), int'(tgt_q.pop_front()));
                end
                if (show_result && !sh_prev) begin
                    if (res_q.size() == 0) begin
                        chk("result_unexpected", 1, 0);
                    end else begin
                        e = res_q.pop_front();
                        chk("result_hit", int'(result_hit), int'(e.hit));
                        chk("score", int'(score), int'(e.score));
                        chk("round_cnt", int'(round_cnt), int'(e.round));
                    end
                end
                if (show_result) sh_len++;
                else if (sh_prev) begin
                    chk("show_len", sh_len, int'(RH));
                    sh_len = 0;
                end
                ms_prev = motor_start;
                sh_prev = show_result;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        res = 1'b1; start = 1'b0; rand_num = 4'd0; motor_busy = 1'b0;
        key_code = 4'd0; key_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        res = 1'b0;
        @(negedge clk);

        // Game 1, round 1: start, roll, latch target 7, busy motor, correct guess.
        start = 1'b1; rand_num = 4'h7; tgt_q.push_back(4'h7);
        @(negedge clk);
        chk("roll_state", int'(state_dbg), 1);
        chk("rand_enable", int'(rand_enable), 1);
        @(negedge clk);
        chk("latch_state", int'(state_dbg), 2);
        chk("motor_start", int'(motor_start), 1);
        chk("rand_enable_off", int'(rand_enable), 0);
        start = 1'b0;
        @(negedge clk);
        chk("spin_state", int'(state_dbg), 3);
        chk("motor_start_off", int'(motor_start), 0);
        motor_busy = 1'b1; start = 1'b1; key_valid = 1'b1; key_code = 4'h7;
        @(negedge clk);
        start = 1'b0; key_valid = 1'b0;
        chk("spin_ignores", int'(state_dbg), 3);
        repeat (4) @(negedge clk);
        chk("spin_busy_hold", int'(state_dbg), 3);
        motor_busy = 1'b0;
        wait_state(3'd4, 10);
        key_valid = 1'b1; key_code = 4'h7;
        res_q.push_back('{hit: 1'b1, score: 4'd1, round: 4'd1});
        @(negedge clk);
        key_valid = 1'b0;
        wait_state(3'd6, 10);
        start = 1'b1; key_valid = 1'b1; key_code = 4'h0;
        @(negedge clk);
        start = 1'b0; key_valid = 1'b0;
        wait_state(3'd1, 10);

        // Game 1, round 2: target A, idle motor, guess times out.
        rand_num = 4'hA; tgt_q.push_back(4'hA);
        wait_state(3'd4, 10);
        res_q.push_back('{hit: 1'b0, score: 4'd1, round: 4'd2});
        n = 0;
        while (state_dbg == 3'd4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_len", n, int'(GT));
        wait_state(3'd7, 20);
        chk("game_over", int'(game_over), 1);
        chk("done_score", int'(score), 1);
        chk("done_round", int'(round_cnt), 2);
        chk("done_target", int'(target), 10);

        // Restart from DONE: counters clear and the game goes straight to ROLL.
        start = 1'b1; rand_num = 4'h5; tgt_q.push_back(4'h5);
        @(negedge clk);
        start = 1'b0;
        chk("restart_state", int'(state_dbg), 1);
        chk("restart_score", int'(score), 0);
        chk("restart_round", int'(round_cnt), 0);
        chk("restart_over", int'(game_over), 0);

        // Game 2, round 1: correct key on the very last timeout cycle.
        wait_state(3'd4, 10);
        repeat (GT - 1) @(negedge clk);
        chk("last_cycle_wait", int'(state_dbg), 4);
        key_valid = 1'b1; key_code = 4'h5;
        res_q.push_back('{hit: 1'b1, score: 4'd1, round: 4'd1});
        @(negedge clk);
        key_valid = 1'b0;
        wait_state(3'd1, 20);

        // Game 2, round 2: asynchronous reset in the middle of WAIT_KEY.
        rand_num = 4'h9; tgt_q.push_back(4'h9);
        wait_state(3'd4, 10);
        repeat (3) @(negedge clk);
        #3 res = 1'b1;
        #1 chk("async_reset_outs", all_outs(), 0);
        @(negedge clk);
        res = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", int'(state_dbg), 0);
        chk("post_reset_roll_off", int'(rand_enable), 0);
        chk("results_drained", res_q.size(), 0);
        chk("targets_drained", tgt_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
